charmem_arbiter: RTL

Shares the single-port character/attribute RAM between the text-mode video pipeline and a host (CPU/debug) port. Video scan-out fetches always win; host reads and writes fill the free cycles in each 8-pixel cell. Sits between the video sync generator (XPOS/YPOS) and the character generator (CHAR/ATTR), and owns the RAM address/write bus.

---
 rtl/charmem_arbiter_pkg.sv | 22 ++
 rtl/charmem_arbiter_addr.sv | 23 ++
 rtl/charmem_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/charmem_arbiter_pkg.sv
// Shared constants for the character/attribute RAM arbiter: text geometry,
// blanking marker, in-flight tag encodings and the packed cell word layout.
package charmem_arbiter_pkg;

    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int CELL_H = 16;
    localparam int MEM_AW = 12;

    localparam logic [9:0] BLANK_POS = 10'h3FF;

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_VID  = 2'd1;
    localparam logic [1:0] TAG_HOST = 2'd2;

    // RAM word layout: {char[15:8], attr[7:0]}
    localparam int CHAR_MSB = 15;
    localparam int CHAR_LSB = 8;
    localparam int ATTR_MSB = 7;
    localparam int ATTR_LSB = 0;

endpackage

// File: rtl/charmem_arbiter_addr.sv
// Text cell (row, col) to linear RAM address, plus a bounds check.
// The multiply by the 80-column pitch is done as (row<<6)+(row<<4).
module charmem_addr
    import charmem_arbiter_pkg::*;
#(
    parameter int AW     = MEM_AW,
    parameter int N_COLS = COLS,
    parameter int N_ROWS = ROWS
)
(
    input  logic [6:0]    col,
    input  logic [5:0]    row,
    output logic [AW-1:0] addr,
    output logic          in_range
);

    // address is truncated to the RAM width; range flag guards both axes
    always_comb begin
        addr     = AW'(({8'd0, row} << 6) + ({8'd0, row} << 4) + {7'd0, col});
        in_range = ({1'b0, col} < 8'(N_COLS)) && ({1'b0, row} < 7'(N_ROWS));
    end

endmodule

// File: rtl/charmem_arbiter.sv
// Single-port character RAM arbiter: video scan-out fetches take priority,
// host reads/writes fill the remaining cycles of each 8-pixel cell.
//
//   tag      | meaning (command issued in the previous cycle)
//   ---------+--------------------------------------------------
//   NONE     | nothing outstanding, MEM_RDATA ignored
//   VID      | video fetch, MEM_RDATA loads {cell_char, cell_attr}
//   HOST     | host access, ACK pulses; reads load rdata
module charmem_arbiter
    import charmem_arbiter_pkg::*;
#(
    parameter int N_COLS   = COLS,
    parameter int N_ROWS   = ROWS,
    parameter int N_CELL_H = CELL_H,
    parameter int AW       = MEM_AW
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [9:0]    xpos,
    input  logic [9:0]    ypos,
    input  logic          req,
    input  logic          we,
    input  logic [6:0]    hcol,
    input  logic [4:0]    hrow,
    input  logic [15:0]   wdata,
    output logic          ack,
    output logic [15:0]   rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata,
    output logic [7:0]    cell_char,
    output logic [7:0]    cell_attr
);

    logic          x_active, y_active;
    logic [7:0]    vcol_next;
    logic [9:0]    last_y_inc;
    logic [6:0]    vid_col;
    logic [5:0]    vid_row;
    logic [AW-1:0] vid_addr, host_addr;
    logic          vid_in_range, host_in_range;
    logic          cell_fetch, vid_fetch, host_go;

    logic          x_active_q, x_active_d;
    logic          hpend_q, hpend_d;
    logic [9:0]    last_y_q, last_y_d;
    logic [1:0]    tag_q, tag_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [15:0]   mem_wdata_q, mem_wdata_d;
    logic          ack_q, ack_d;
    logic [15:0]   rdata_q, rdata_d;
    logic [7:0]    cell_char_q, cell_char_d;
    logic [7:0]    cell_attr_q, cell_attr_d;

    // video cell coordinates: next column on this line, or column 0 of the
    // upcoming line while a line-start fetch is pending
    always_comb begin
        x_active   = (xpos != BLANK_POS);
        y_active   = (ypos != BLANK_POS);
        vcol_next  = {1'b0, xpos[9:3]} + 8'd1;
        last_y_inc = last_y_q + 10'd1;
        if (hpend_q) begin
            vid_col = '0;
            vid_row = (last_y_inc == 10'(N_ROWS * N_CELL_H)) ?
                      6'd0 : 6'(last_y_inc / 10'(N_CELL_H));
        end else begin
            vid_col = vcol_next[6:0];
            vid_row = 6'(last_y_q / 10'(N_CELL_H));
        end
    end

    charmem_addr #(.AW(AW), .N_COLS(N_COLS), .N_ROWS(N_ROWS)) u_vid_addr (
        .col      (vid_col),
        .row      (vid_row),
        .addr     (vid_addr),
        .in_range (vid_in_range)
    );

    charmem_addr #(.AW(AW), .N_COLS(N_COLS), .N_ROWS(N_ROWS)) u_host_addr (
        .col      (hcol),
        .row      ({1'b0, hrow}),
        .addr     (host_addr),
        .in_range (host_in_range)
    );

    // slot decision: video owns the slot when it fetches; the host may only
    // start when nothing of its own is in flight and ACK is not showing
    always_comb begin
        cell_fetch = y_active && (xpos[2:0] == 3'd6) && !vcol_next[7];
        vid_fetch  = (hpend_q || cell_fetch) && vid_in_range;
        host_go    = req && !vid_fetch && (tag_q != TAG_HOST) && !ack_q;
    end

    // next-state: retire last cycle's command, then issue this cycle's
    always_comb begin
        x_active_d  = x_active;
        hpend_d     = !x_active && x_active_q;
        last_y_d    = (x_active && y_active) ? ypos : last_y_q;
        tag_d       = TAG_NONE;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        ack_d       = 1'b0;
        rdata_d     = rdata_q;
        cell_char_d = cell_char_q;
        cell_attr_d = cell_attr_q;

        case (tag_q)
            TAG_VID: begin
                cell_char_d = mem_rdata[CHAR_MSB:CHAR_LSB];
                cell_attr_d = mem_rdata[ATTR_MSB:ATTR_LSB];
            end
            TAG_HOST: begin
                ack_d = 1'b1;
                // mem_we_q still reflects whether the returning access was a write
                if (!mem_we_q) begin
                    rdata_d = mem_rdata;
                end
            end
            default: ;
        endcase

        if (vid_fetch) begin
            mem_addr_d = vid_addr;
            tag_d      = TAG_VID;
        end else if (host_go) begin
            if (host_in_range) begin
                mem_addr_d = host_addr;
                mem_we_d   = we;
                if (we) begin
                    mem_wdata_d = wdata;
                end
                tag_d = TAG_HOST;
            end else begin
                // bad address never reaches the RAM; complete immediately
                ack_d   = 1'b1;
                rdata_d = '0;
            end
        end
    end

    // state registers, all cleared by reset so an in-flight command is lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_active_q  <= 1'b0;
            hpend_q     <= 1'b0;
            last_y_q    <= '0;
            tag_q       <= TAG_NONE;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            cell_char_q <= '0;
            cell_attr_q <= '0;
        end else begin
            x_active_q  <= x_active_d;
            hpend_q     <= hpend_d;
            last_y_q    <= last_y_d;
            tag_q       <= tag_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            cell_char_q <= cell_char_d;
            cell_attr_q <= cell_attr_d;
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign cell_char = cell_char_q;
    assign cell_attr = cell_attr_q;

endmodule
